// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file with clear sequencer and debug read port
//
// Purpose : DEPTH = 2**ADDR_W entries of DATA_W bits, two combinational read
//           ports, one combinational debug read port and one write port.
//           A clr_req starts a DEPTH-cycle sweep that zeroes every entry;
//           writes arriving during the sweep are dropped and flagged.
// Macro   : REGFILE_BYPASS_EN - when defined, rd1/rd2 forward wd3 for a
//           same-cycle write to the addressed entry (IDLE only).
// Ports   : clk            - clock, rising edge
//           rst            - asynchronous active-low reset
//           we3/wa3/wd3    - write enable / address / data
//           ra1/rd1        - read port 1 address / data
//           ra2/rd2        - read port 2 address / data
//           dbg_ra/dbg_rd  - debug read address / data (never forwarded)
//           clr_req        - start full clear
//           busy           - clear sweep in progress
//           wr_drop        - sticky: a write arrived while busy

module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic [ADDR_W-1:0] dbg_ra,
    output logic [DATA_W-1:0] dbg_rd,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_ptr;
    logic              wr_ok;

    // Entry 0 is read-only-zero when ZERO_REG is set, so its storage never changes.
    always_comb begin
        wr_ok = we3;
        if ((ZERO_REG != 0) && (wa3 == '0)) begin
            wr_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            state   <= S_IDLE;
            clr_ptr <= '0;
            busy    <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // A write on the same edge as clr_req still lands; the sweep
                    // then zeroes it along with everything else.
                    if (wr_ok) begin
                        regs[wa3] <= wd3;
                    end
                    if (clr_req) begin
                        state   <= S_CLEAR;
                        clr_ptr <= '0;
                        busy    <= 1'b1;
                        wr_drop <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    regs[clr_ptr] <= '0;
                    if (we3) begin
                        wr_drop <= 1'b1;
                    end
                    if (clr_ptr == LAST_PTR) begin
                        state   <= S_IDLE;
                        clr_ptr <= '0;
                        busy    <= 1'b0;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding is suppressed in reset so reads stay zero while rst is low.
    logic fwd_ok;
    assign fwd_ok = rst && (state == S_IDLE) && we3;
`endif

    always_comb begin
        rd1    = regs[ra1];
        rd2    = regs[ra2];
        dbg_rd = regs[dbg_ra];
`ifdef REGFILE_BYPASS_EN
        if (fwd_ok && (ra1 == wa3)) begin
            rd1 = wd3;
        end
        if (fwd_ok && (ra2 == wa3)) begin
            rd2 = wd3;
        end
`endif
        // Applied last so that forwarding can never expose a write to entry 0.
        if (ZERO_REG != 0) begin
            if (ra1 == '0) begin
                rd1 = '0;
            end
            if (ra2 == '0) begin
                rd2 = '0;
            end
            if (dbg_ra == '0) begin
                dbg_rd = '0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - self-checking bench for reg_file_param (ZERO_REG=1 and ZERO_REG=0 instances)

module tb_reg_file_param;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          we3     = 1'b0;
    logic          clr_req = 1'b0;
    logic [AW-1:0] wa3     = '0;
    logic [AW-1:0] ra1     = '0;
    logic [AW-1:0] ra2     = '0;
    logic [AW-1:0] dbg_ra  = '0;
    logic [DW-1:0] wd3     = '0;

    logic [DW-1:0] rd1_z1, rd2_z1, dbg_z1, rd1_z0, rd2_z0, dbg_z0;
    logic          busy_z1, drop_z1, busy_z0, drop_z0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut_z1 (
        .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_z1), .rd2(rd2_z1),
        .dbg_ra(dbg_ra), .dbg_rd(dbg_z1), .clr_req(clr_req),
        .busy(busy_z1), .wr_drop(drop_z1)
    );

    reg_file_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut_z0 (
        .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1_z0), .rd2(rd2_z0),
        .dbg_ra(dbg_ra), .dbg_rd(dbg_z0), .clr_req(clr_req),
        .busy(busy_z0), .wr_drop(drop_z0)
    );

    // Reference model: index 0 = ZERO_REG=0 instance, index 1 = ZERO_REG=1 instance.
    logic [DW-1:0] m_mem [2][DEPTH];
    bit            m_busy;
    bit            m_drop;
    int            m_swept;

    task automatic model_reset();
        for (int z = 0; z < 2; z++)
            for (int a = 0; a < DEPTH; a++)
                m_mem[z][a] = '0;
        m_busy  = 1'b0;
        m_drop  = 1'b0;
        m_swept = 0;
    endtask

    task automatic model_edge();
        if (!rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (we3) begin
                m_mem[0][wa3] = wd3;
                if (wa3 != 0) m_mem[1][wa3] = wd3;
            end
            if (clr_req) begin
                m_busy  = 1'b1;
                m_swept = 0;
                m_drop  = 1'b0;
            end
        end else begin
            if (we3) m_drop = 1'b1;
            m_mem[0][m_swept] = '0;
            m_mem[1][m_swept] = '0;
            m_swept++;
            if (m_swept == DEPTH) m_busy = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(int zr, logic [AW-1:0] a, bit port_fwd);
        if (zr == 1 && a == 0) return '0;
        if (port_fwd && BYPASS && rst && !m_busy && we3 && a == wa3) return wd3;
        return m_mem[zr][a];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_all(string tag);
        chk({tag, ":z1.rd1"},  32'(rd1_z1),  32'(exp_rd(1, ra1, 1'b1)));
        chk({tag, ":z1.rd2"},  32'(rd2_z1),  32'(exp_rd(1, ra2, 1'b1)));
        chk({tag, ":z1.dbg"},  32'(dbg_z1),  32'(exp_rd(1, dbg_ra, 1'b0)));
        chk({tag, ":z0.rd1"},  32'(rd1_z0),  32'(exp_rd(0, ra1, 1'b1)));
        chk({tag, ":z0.rd2"},  32'(rd2_z0),  32'(exp_rd(0, ra2, 1'b1)));
        chk({tag, ":z0.dbg"},  32'(dbg_z0),  32'(exp_rd(0, dbg_ra, 1'b0)));
        chk({tag, ":z1.busy"}, 32'(busy_z1), 32'(m_busy));
        chk({tag, ":z0.busy"}, 32'(busy_z0), 32'(m_busy));
        chk({tag, ":z1.drop"}, 32'(drop_z1), 32'(m_drop));
        chk({tag, ":z0.drop"}, 32'(drop_z0), 32'(m_drop));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        bit            we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] r1;
        logic [AW-1:0] r2;
        logic [DW-1:0] e1_z1;
        logic [DW-1:0] e2_z1;
        logic [DW-1:0] e1_z0;
        logic [DW-1:0] e2_z0;
    } vec_t;

    vec_t tbl [5];
    int   busy_cnt;

    initial begin
        tbl[0] = '{1'b1, 3'd3, 8'hA5, 3'd3, 3'd5, 8'hA5, 8'h00, 8'hA5, 8'h00};
        tbl[1] = '{1'b1, 3'd5, 8'h3C, 3'd3, 3'd5, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
        tbl[2] = '{1'b1, 3'd0, 8'hFF, 3'd0, 3'd3, 8'h00, 8'hA5, 8'hFF, 8'hA5};
        tbl[3] = '{1'b0, 3'd3, 8'h00, 3'd5, 3'd0, 8'h3C, 8'h00, 8'h3C, 8'hFF};
        tbl[4] = '{1'b1, 3'd3, 8'h5A, 3'd3, 3'd5, 8'h5A, 8'h3C, 8'h5A, 8'h3C};

        model_reset();

        // Reads stay zero in reset even with a write pending on the same address.
        we3 = 1'b1; wa3 = 3'd2; wd3 = 8'h99; ra1 = 3'd2; ra2 = 3'd2; dbg_ra = 3'd2;
        #12;
        chk("rst_hold:z1.rd1", 32'(rd1_z1), 32'h0);
        chk("rst_hold:z0.rd2", 32'(rd2_z0), 32'h0);
        check_all("rst_hold");
        @(negedge clk);
        rst = 1'b1; we3 = 1'b0;
        #1;

        for (int a = 0; a < DEPTH; a++) begin
            ra1 = AW'(a); ra2 = AW'(a); dbg_ra = AW'(a);
            #1;
            chk("reset:z0.rd1", 32'(rd1_z0), 32'h0);
            chk("reset:z0.rd2", 32'(rd2_z0), 32'h0);
            chk("reset:z0.dbg", 32'(dbg_z0), 32'h0);
        end
        chk("reset:busy",  32'(busy_z1), 32'h0);
        chk("reset:wdrop", 32'(drop_z1), 32'h0);

        foreach (tbl[i]) begin
            we3 = tbl[i].we; wa3 = tbl[i].wa; wd3 = tbl[i].wd;
            ra1 = tbl[i].r1; ra2 = tbl[i].r2; dbg_ra = tbl[i].wa;
            #1;
            check_all("tbl_pre");
            tick();
            we3 = 1'b0;
            #1;
            chk($sformatf("tbl%0d:z1.rd1", i), 32'(rd1_z1), 32'(tbl[i].e1_z1));
            chk($sformatf("tbl%0d:z1.rd2", i), 32'(rd2_z1), 32'(tbl[i].e2_z1));
            chk($sformatf("tbl%0d:z0.rd1", i), 32'(rd1_z0), 32'(tbl[i].e1_z0));
            chk($sformatf("tbl%0d:z0.rd2", i), 32'(rd2_z0), 32'(tbl[i].e2_z0));
            check_all("tbl_post");
        end
        dbg_ra = 3'd0;
        #1;
        chk("zero_reg:z1.dbg", 32'(dbg_z1), 32'h00);
        chk("zero_reg:z0.dbg", 32'(dbg_z0), 32'hFF);

        // Fill with 0x11*addr, then run a full clear with a dropped write inside it.
        for (int a = 0; a < DEPTH; a++) begin
            we3 = 1'b1; wa3 = AW'(a); wd3 = DW'(8'h11 * a);
            tick();
        end
        we3 = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy_z1) busy_cnt++;
            if (k == 4) begin
                dbg_ra = 3'd2; #1;
                chk("mid_clr:dbg2", 32'(dbg_z1), 32'h00);
                dbg_ra = 3'd6; #1;
                chk("mid_clr:dbg6", 32'(dbg_z1), 32'h66);
            end
            if (k == 2) begin
                we3 = 1'b1; wa3 = 3'd7; wd3 = 8'h77; clr_req = 1'b1;
            end
            #1;
            check_all("clr");
            tick();
            we3 = 1'b0; clr_req = 1'b0;
        end
        chk("clr:busy_cycles", 32'(busy_cnt), 32'd8);
        for (int a = 0; a < DEPTH; a++) begin
            dbg_ra = AW'(a); #1;
            chk("after_clr:z0.dbg", 32'(dbg_z0), 32'h0);
        end
        chk("after_clr:wdrop", 32'(drop_z1), 32'h1);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("reclr:wdrop", 32'(drop_z1), 32'h0);
        for (int k = 0; k < DEPTH; k++) tick();
        check_all("reclr_done");

        // Reset in the middle of a sweep (after three entries cleared).
        for (int a = 0; a < DEPTH; a++) begin
            we3 = 1'b1; wa3 = AW'(a); wd3 = 8'h55;
            tick();
        end
        we3 = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("midrst:busy", 32'(busy_z1), 32'h0);
        for (int a = 0; a < DEPTH; a++) begin
            dbg_ra = AW'(a); #1;
            chk("midrst:z0.dbg", 32'(dbg_z0), 32'h0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        we3 = 1'b1; wa3 = 3'd1; wd3 = 8'h42;
        tick();
        we3 = 1'b0; ra1 = 3'd1; dbg_ra = 3'd1;
        #1;
        chk("post_rst:z1.rd1", 32'(rd1_z1), 32'h42);
        chk("post_rst:z0.dbg", 32'(dbg_z0), 32'h42);
        check_all("post_rst");

        // Randomised traffic with occasional clears.
        for (int n = 0; n < 400; n++) begin
            we3     = 1'($urandom_range(0, 1));
            wa3     = AW'($urandom);
            wd3     = DW'($urandom);
            ra1     = AW'($urandom);
            ra2     = ($urandom_range(0, 3) == 0) ? wa3 : AW'($urandom);
            dbg_ra  = AW'($urandom);
            clr_req = ($urandom_range(0, 39) == 0);
            #1;
            check_all("rand");
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
